// File: rtl/service_window_pkg.sv
// Shared types and constants for the service-window scheduler.
// State encoding is fixed so it can be decoded from a state probe.
package service_window_pkg;

  localparam int LENW_DEF     = 16;
  localparam int OPEN_TIMEOUT = 2;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARB   = 3'd1,
    START = 3'd2,
    OPEN  = 3'd3,
    RUN   = 3'd4
  } state_e;

endpackage

// File: rtl/service_window_sched_if.sv
// Client/timer-facing bundle of the scheduler; master is the scheduler side.
interface service_window_sched_if #(
  parameter int NREQ = 4,
  parameter int LENW = service_window_pkg::LENW_DEF,
  parameter int IDW  = 2
);
  logic [NREQ-1:0]           req;
  logic [NREQ-1:0][LENW-1:0] len;
  logic [NREQ-1:0]           gnt;
  logic [IDW-1:0]            gnt_id;
  logic [LENW-1:0]           swlen;
  logic                      init;
  logic                      swstat;
  logic                      busy;
  logic                      done;
  logic                      fault;

  modport master (
    input  req, len, swstat,
    output gnt, gnt_id, swlen, init, busy, done, fault
  );

  modport slave (
    output req, len, swstat,
    input  gnt, gnt_id, swlen, init, busy, done, fault
  );
endinterface

// File: rtl/service_window_sched_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr_i, wrapping.
module service_window_sched_rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDW-1:0]  ptr_i,
  output logic [NREQ-1:0] win_oh_o,
  output logic [IDW-1:0]  win_idx_o
);
  logic [NREQ-1:0] rot;
  logic            vld;

  // Rotate so bit 0 is the pointer position; lowest set bit then wins.
  assign rot = NREQ'({req_i, req_i} >> ptr_i);

  always_comb begin
    win_idx_o = '0;
    vld       = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        vld       = 1'b1;
        win_idx_o = IDW'((int'(ptr_i) + k) % NREQ);
      end
    end
  end

  assign win_oh_o = vld ? (NREQ'(1) << win_idx_o) : '0;

endmodule

// File: rtl/service_window_sched.sv
// Round-robin owner of one service_window timer: grant, fire INIT, watch SWSTAT,
// report DONE or FAULT per grant.
module service_window_sched
  import service_window_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int LENW = LENW_DEF,
  parameter int IDW  = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  service_window_sched_if.master  bus
);
  state_e          state_q, state_d;
  logic [IDW-1:0]  ptr_q, ptr_d;
  logic [IDW-1:0]  gnt_id_q, gnt_id_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [LENW-1:0] swlen_q, swlen_d;
  logic [1:0]      ocnt_q, ocnt_d;
  logic            init_q, init_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            fault_q, fault_d;
  logic [NREQ-1:0] win_oh;
  logic [IDW-1:0]  win_idx;

  service_window_sched_rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .req_i     (bus.req),
    .ptr_i     (ptr_q),
    .win_oh_o  (win_oh),
    .win_idx_o (win_idx)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      gnt_id_q <= '0;
      gnt_q    <= '0;
      swlen_q  <= '0;
      ocnt_q   <= '0;
      init_q   <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      gnt_id_q <= gnt_id_d;
      gnt_q    <= gnt_d;
      swlen_q  <= swlen_d;
      ocnt_q   <= ocnt_d;
      init_q   <= init_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      fault_q  <= fault_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    gnt_id_d = gnt_id_q;
    gnt_d    = gnt_q;
    swlen_d  = swlen_q;
    ocnt_d   = ocnt_q;
    init_d   = 1'b1;
    busy_d   = busy_q;
    done_d   = 1'b0;
    fault_d  = 1'b0;
    unique case (state_q)
      // Never grant while a window (e.g. one surviving a reset) is still open.
      IDLE: if (bus.swstat) state_d = ARB;
      ARB: begin
        if (|bus.req) begin
          gnt_d    = win_oh;
          gnt_id_d = win_idx;
          swlen_d  = bus.len[win_idx];
          busy_d   = 1'b1;
          ptr_d    = (win_idx == IDW'(NREQ - 1)) ? '0 : win_idx + 1'b1;
          state_d  = START;
        end
      end
      START: begin
        init_d  = 1'b0;
        ocnt_d  = '0;
        state_d = OPEN;
      end
      OPEN: begin
        if (!bus.swstat) begin
          state_d = RUN;
        end else if (ocnt_q == 2'(OPEN_TIMEOUT - 1)) begin
          fault_d = 1'b1;
          gnt_d   = '0;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          ocnt_d = ocnt_q + 1'b1;
        end
      end
      RUN: begin
        if (bus.swstat) begin
          done_d  = 1'b1;
          gnt_d   = '0;
          busy_d  = 1'b0;
          state_d = ARB;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.gnt    = gnt_q;
  assign bus.gnt_id = gnt_id_q;
  assign bus.swlen  = swlen_q;
  assign bus.init   = init_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.fault  = fault_q;

endmodule
